// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stall request / mul-div handshake bundle between pipeline and pipe_ctrl
interface pipe_ctrl_if;
    logic        stallreq_id;
    logic        stallreq_mem;
    logic        md_req;
    logic        md_is_div;
    logic        md_start;
    logic        md_busy;
    logic        md_done;
    logic [5:0]  stall;
    logic [31:0] stall_cycles;

    modport master (
        output stallreq_id, stallreq_mem, md_req, md_is_div,
        input  md_start, md_busy, md_done, stall, stall_cycles
    );

    modport slave (
        input  stallreq_id, stallreq_mem, md_req, md_is_div,
        output md_start, md_busy, md_done, stall, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall priority resolver and mul/div latency sequencer
module pipe_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic [31:0] stall_cycles_q;
    logic [5:0]  stall_vec;
    logic        md_stall;
    logic        md_start_o;
    logic        md_busy_o;
    logic        md_done_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 6'd0;
            stall_cycles_q <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (stall_vec[0])
                stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.md_req) begin
                    cnt_nxt   = bus.md_is_div ? DIV_CNT : MUL_CNT;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // The unit keeps computing through MEM waits; only DONE holds.
                cnt_nxt = cnt - 6'd1;
                if (cnt <= 6'd1)
                    state_nxt = DONE;
            end
            DONE: begin
                if (!stall_vec[3])
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        md_stall   = 1'b0;
        md_start_o = 1'b0;
        md_busy_o  = 1'b0;
        md_done_o  = 1'b0;
        stall_vec  = 6'b000000;
        if (!rst) begin
            md_start_o = (state == IDLE) && bus.md_req;
            md_busy_o  = (state == BUSY);
            md_done_o  = (state == DONE);
            md_stall   = md_start_o || md_busy_o;
            if (bus.stallreq_mem)
                stall_vec = 6'b011111;
            else if (md_stall)
                stall_vec = 6'b001111;
            else if (bus.stallreq_id)
                stall_vec = 6'b000111;
        end
    end

    assign bus.md_start     = md_start_o;
    assign bus.md_busy      = md_busy_o;
    assign bus.md_done      = md_done_o;
    assign bus.stall        = stall_vec;
    assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   cyc_n = 0;
    int   start_cnt = 0;
    int   last_start = 0;
    int   prev_start = 0;

    pipe_ctrl_if bus();

    pipe_ctrl #(.MUL_LAT(4), .DIV_LAT(33)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic settle();
        #4;
        if (bus.md_start === 1'b1) begin
            start_cnt++;
            prev_start = last_start;
            last_start = cyc_n;
        end
    endtask

    task automatic set_in(input logic id, input logic mem, input logic req, input logic div);
        bus.stallreq_id  = id;
        bus.stallreq_mem = mem;
        bus.md_req       = req;
        bus.md_is_div    = div;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0);
        step(); settle();
        step(); settle();
        start_cnt = 0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1, 0, 1, 0);

        // reset hold with requests asserted
        for (int i = 0; i < 3; i++) begin
            step(); settle();
            check("rst_stall", 32'(bus.stall), 32'h00);
            check("rst_start", 32'(bus.md_start), 32'h0);
            check("rst_sc", bus.stall_cycles, 32'd0);
        end
        step(); rst = 1'b0; settle();
        check("rel_stall", 32'(bus.stall), 32'h0F);
        check("rel_start", 32'(bus.md_start), 32'h1);

        // clean multiply
        do_reset();
        step(); rst = 1'b0; set_in(0, 0, 1, 0); settle();
        check("mul_t_start", 32'(bus.md_start), 32'h1);
        check("mul_t_stall", 32'(bus.stall), 32'h0F);
        for (int i = 1; i <= 3; i++) begin
            step(); settle();
            check("mul_busy_start", 32'(bus.md_start), 32'h0);
            check("mul_busy", 32'(bus.md_busy), 32'h1);
            check("mul_busy_stall", 32'(bus.stall), 32'h0F);
        end
        step(); settle();
        check("mul_done", 32'(bus.md_done), 32'h1);
        check("mul_done_stall", 32'(bus.stall), 32'h00);
        check("mul_done_start", 32'(bus.md_start), 32'h0);
        step(); set_in(0, 0, 0, 0); settle();
        check("mul_idle_done", 32'(bus.md_done), 32'h0);
        check("mul_idle_busy", 32'(bus.md_busy), 32'h0);
        check("mul_sc", bus.stall_cycles, 32'd4);
        check("mul_starts", 32'(start_cnt), 32'd1);

        // divide finishing under a MEM wait
        do_reset();
        step(); rst = 1'b0; set_in(0, 0, 1, 1); settle();
        check("div_t_start", 32'(bus.md_start), 32'h1);
        for (int i = 1; i <= 32; i++) begin
            step(); settle();
        end
        check("div_last_busy", 32'(bus.md_busy), 32'h1);
        step(); set_in(0, 1, 1, 1); settle();
        check("div_mem1_stall", 32'(bus.stall), 32'h1F);
        check("div_mem1_done", 32'(bus.md_done), 32'h1);
        step(); settle();
        check("div_mem2_stall", 32'(bus.stall), 32'h1F);
        check("div_mem2_done", 32'(bus.md_done), 32'h1);
        step(); set_in(0, 0, 1, 1); settle();
        check("div_rel_done", 32'(bus.md_done), 32'h1);
        check("div_rel_stall", 32'(bus.stall), 32'h00);
        step(); set_in(0, 0, 0, 0); settle();
        check("div_idle_done", 32'(bus.md_done), 32'h0);
        check("div_sc", bus.stall_cycles, 32'd35);
        check("div_starts", 32'(start_cnt), 32'd1);

        // priority: ID stall under a multiply, then MEM on top
        do_reset();
        step(); rst = 1'b0; set_in(1, 0, 1, 0); settle();
        check("pri_t_stall", 32'(bus.stall), 32'h0F);
        for (int i = 1; i <= 3; i++) begin
            step(); settle();
        end
        check("pri_busy_stall", 32'(bus.stall), 32'h0F);
        step(); settle();
        check("pri_done_stall", 32'(bus.stall), 32'h07);
        step(); set_in(1, 0, 0, 0); settle();
        check("pri_idle_stall", 32'(bus.stall), 32'h07);
        step(); set_in(1, 1, 1, 0); settle();
        check("pri_mem_stall", 32'(bus.stall), 32'h1F);
        check("pri_mem_start", 32'(bus.md_start), 32'h1);

        // back-to-back divide then multiply
        do_reset();
        step(); rst = 1'b0; set_in(0, 0, 1, 1); settle();
        for (int i = 1; i <= 33; i++) begin
            step(); settle();
        end
        check("b2b_div_done", 32'(bus.md_done), 32'h1);
        step(); set_in(0, 0, 1, 0); settle();
        check("b2b_mul_start", 32'(bus.md_start), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            step(); settle();
        end
        check("b2b_mul_done", 32'(bus.md_done), 32'h1);
        step(); set_in(0, 0, 0, 0); settle();
        check("b2b_starts", 32'(start_cnt), 32'd2);
        check("b2b_spacing", 32'(last_start - prev_start), 32'd34);
        check("b2b_sc", bus.stall_cycles, 32'd37);

        // reset in the middle of a divide
        do_reset();
        step(); rst = 1'b0; set_in(0, 0, 1, 1); settle();
        for (int i = 1; i <= 9; i++) begin
            step(); settle();
        end
        step(); rst = 1'b1; settle();
        check("mrst_stall", 32'(bus.stall), 32'h00);
        check("mrst_busy", 32'(bus.md_busy), 32'h0);
        check("mrst_start", 32'(bus.md_start), 32'h0);
        step(); rst = 1'b0; settle();
        check("mrst_restart", 32'(bus.md_start), 32'h1);
        check("mrst_idle_busy", 32'(bus.md_busy), 32'h0);
        check("mrst_restall", 32'(bus.stall), 32'h0F);
        check("mrst_sc", bus.stall_cycles, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
